// File: rtl/branch_resolve_bht_pkg.sv
// Shared types and constants for the branch resolver / BHT slice.
package branch_resolve_bht_pkg;

  // Branch compare op codes carried on CMPOp
  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_BEQ  = 3'd1;
  localparam logic [2:0] CMP_BNE  = 3'd2;
  localparam logic [2:0] CMP_BLEZ = 3'd3;
  localparam logic [2:0] CMP_BGTZ = 3'd4;
  localparam logic [2:0] CMP_BLTZ = 3'd5;
  localparam logic [2:0] CMP_BGEZ = 3'd6;

  // 2-bit saturating counter encodings
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    BHT_IDLE  = 1'b0,
    BHT_CLEAR = 1'b1
  } bht_state_e;

  // Result of the condition evaluator
  typedef struct packed {
    logic flag;
    logic is_branch;
  } cond_res_t;

  // Saturating counter step toward the resolved direction
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'(1);
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_cond_eval.sv
// Combinational MIPS branch condition evaluator.
//  gpr_rs/gpr_rt : forwarded operands
//  cmp_op        : branch compare op code
//  res_c         : {flag, is_branch}
module branch_resolve_bht_cond_eval
  import branch_resolve_bht_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] gpr_rs,
  input  logic [DATA_W-1:0] gpr_rt,
  input  logic [2:0]        cmp_op,
  output cond_res_t         res_c
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = gpr_rs[DATA_W-1];
  assign rs_zero = (gpr_rs == '0);

  // Decode op and evaluate condition; undefined codes are not branches
  always_comb begin
    res_c = '0;
    case (cmp_op)
      CMP_BEQ:  res_c = '{flag: (gpr_rs == gpr_rt), is_branch: 1'b1};
      CMP_BNE:  res_c = '{flag: (gpr_rs != gpr_rt), is_branch: 1'b1};
      CMP_BLEZ: res_c = '{flag: (rs_neg | rs_zero), is_branch: 1'b1};
      CMP_BGTZ: res_c = '{flag: (~rs_neg & ~rs_zero), is_branch: 1'b1};
      CMP_BLTZ: res_c = '{flag: rs_neg, is_branch: 1'b1};
      CMP_BGEZ: res_c = '{flag: ~rs_neg, is_branch: 1'b1};
      default:  res_c = '0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// D-stage branch resolver with a PC-indexed table of 2-bit counters.
//  pc_f -> pred_taken_f      : F-stage prediction lookup (0 while busy)
//  res_valid/pc_d/gpr_rs/gpr_rt/CMPOp/pred_taken_d : D-stage resolve + train
//  flag, mispredict          : combinational resolve results
//  flush_req -> busy         : table reinit sequencer
//  branch_cnt, miss_cnt      : saturating statistics
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  CTR_INIT  = 2'b01,
  parameter int unsigned STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc_f,
  output logic              pred_taken_f,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   pc_d,
  input  logic [DATA_W-1:0] gpr_rs,
  input  logic [DATA_W-1:0] gpr_rt,
  input  logic [2:0]        CMPOp,
  input  logic              pred_taken_d,
  output logic              flag,
  output logic              mispredict,
  input  logic              flush_req,
  output logic              busy,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  bht_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [1:0]        ctr_q [BHT_DEPTH];
  logic [1:0]        ctr_d [BHT_DEPTH];
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [IDX_W-1:0]  idx_f, idx_d;
  logic              train;
  cond_res_t         cond;
  logic              unused_pc_bits;

  branch_resolve_bht_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .gpr_rs (gpr_rs),
    .gpr_rt (gpr_rt),
    .cmp_op (CMPOp),
    .res_c  (cond)
  );

  assign idx_f = pc_f[IDX_W+1:2];
  assign idx_d = pc_d[IDX_W+1:2];
  assign unused_pc_bits = ^{pc_f[PC_W-1:IDX_W+2], pc_f[1:0], pc_d[PC_W-1:IDX_W+2], pc_d[1:0]};

  assign busy         = (state_q == BHT_CLEAR);
  assign pred_taken_f = ~busy & ctr_q[idx_f][1];
  assign flag         = cond.flag;
  assign mispredict   = res_valid & cond.is_branch & (cond.flag != pred_taken_d);
  assign branch_cnt   = branch_cnt_q;
  assign miss_cnt     = miss_cnt_q;

  // Flush sequencer, training and statistics next-state
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ctr_d        = ctr_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    train        = 1'b0;

    case (state_q)
      BHT_IDLE: begin
        // A flush request wins over a branch resolving in the same cycle
        if (flush_req) begin
          state_d = BHT_CLEAR;
          ptr_d   = '0;
        end else begin
          train = res_valid & cond.is_branch;
        end
      end
      BHT_CLEAR: begin
        ctr_d[ptr_q] = CTR_INIT;
        ptr_d        = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(BHT_DEPTH - 1)) state_d = BHT_IDLE;
      end
    endcase

    if (train) begin
      ctr_d[idx_d] = ctr_update(ctr_q[idx_d], cond.flag);
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if (mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + STAT_W'(1);
    end
  end

  // State, table and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BHT_IDLE;
      ptr_q        <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < int'(BHT_DEPTH); i++) ctr_q[i] <= CTR_INIT;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      ctr_q        <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
`timescale 1ns/1ps
module tb_branch_resolve_bht;
  import branch_resolve_bht_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f, pc_d;
  logic        res_valid, res_valid2;
  logic [31:0] gpr_rs, gpr_rt;
  logic [2:0]  cmp_op;
  logic        pred_taken_d;
  logic        flush_req;
  logic        pred_taken_f, flag, mispredict, busy;
  logic [31:0] branch_cnt, miss_cnt;
  logic        pred_taken_f2, flag2, mispredict2, busy2;
  logic [3:0]  branch_cnt2, miss_cnt2;

  int errors = 0;
  int checks = 0;

  branch_resolve_bht u_dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .res_valid(res_valid), .pc_d(pc_d), .gpr_rs(gpr_rs), .gpr_rt(gpr_rt),
    .CMPOp(cmp_op), .pred_taken_d(pred_taken_d), .flag(flag),
    .mispredict(mispredict), .flush_req(flush_req), .busy(busy),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  // Narrow-statistics instance for the saturation corner
  branch_resolve_bht #(.BHT_DEPTH(4), .STAT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken_f2),
    .res_valid(res_valid2), .pc_d(pc_d), .gpr_rs(gpr_rs), .gpr_rt(gpr_rt),
    .CMPOp(cmp_op), .pred_taken_d(pred_taken_d), .flag(flag2),
    .mispredict(mispredict2), .flush_req(flush_req), .busy(busy2),
    .branch_cnt(branch_cnt2), .miss_cnt(miss_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        pred_d;
    logic        valid;
    logic        exp_flag;
    logic        exp_mis;
  } cond_vec_t;

  cond_vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cycles;
    int bad_pred;
    int ones;

    vecs[0]  = '{CMP_BGEZ, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{CMP_BGEZ, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{CMP_BLEZ, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{CMP_BGTZ, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{CMP_BEQ,  32'h0000_0005, 32'h5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{CMP_BNE,  32'h0000_0005, 32'h5, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{CMP_NONE, 32'h0000_0005, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd7,     32'h0000_0005, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{CMP_BLTZ, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{CMP_BLTZ, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{CMP_BLEZ, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{CMP_BGTZ, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{CMP_BNE,  32'h0000_0005, 32'h6, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{CMP_BEQ,  32'h0000_0000, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; pc_f = '0; pc_d = '0; res_valid = 1'b0; res_valid2 = 1'b0;
    gpr_rs = '0; gpr_rt = '0; cmp_op = CMP_NONE; pred_taken_d = 1'b0; flush_req = 1'b0;

    // Reset state: every entry weakly not-taken, stats clear, idle
    #1;
    for (int i = 0; i < 64; i++) begin
      pc_f = 32'(i * 4);
      #1;
      check($sformatf("reset_pred[%0d]", i), pred_taken_f, 1'b0);
    end
    check("reset_busy", busy, 1'b0);
    check("reset_branch_cnt", branch_cnt, 32'd0);
    check("reset_miss_cnt", miss_cnt, 32'd0);

    // Condition table, applied while reset holds the table still
    for (int i = 0; i < 14; i++) begin
      cmp_op = vecs[i].op; gpr_rs = vecs[i].rs; gpr_rt = vecs[i].rt;
      pred_taken_d = vecs[i].pred_d; res_valid = vecs[i].valid;
      #1;
      check($sformatf("flag[%0d]", i), flag, vecs[i].exp_flag);
      check($sformatf("mispredict[%0d]", i), mispredict, vecs[i].exp_mis);
    end
    res_valid = 1'b0;

    // Train 0x3000 taken three times with a not-taken prediction
    @(negedge clk);
    rst_n = 1'b1;
    pc_f = 32'h3000; pc_d = 32'h3000; cmp_op = CMP_BEQ; gpr_rs = 32'd5; gpr_rt = 32'd5;
    pred_taken_d = 1'b0; res_valid = 1'b1;
    #1;
    check("t3_pred_pre", pred_taken_f, 1'b0);
    check("t3_mis_pre", mispredict, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 3) res_valid = 1'b0;
      #1;
      check($sformatf("t3_pred_after%0d", j), pred_taken_f, 1'b1);
      if (j < 3) check($sformatf("t3_mis_after%0d", j), mispredict, 1'b1);
    end
    check("t3_branch_cnt", branch_cnt, 32'd3);
    check("t3_miss_cnt", miss_cnt, 32'd3);
    pc_f = 32'h3100; #1;
    check("t3_alias_pred", pred_taken_f, 1'b1);
    pc_f = 32'h3004; #1;
    check("t3_neighbour_pred", pred_taken_f, 1'b0);

    // Same-index read during training shows the pre-edge counter
    @(negedge clk);
    pc_f = 32'h3008; pc_d = 32'h3008; pred_taken_d = 1'b1; res_valid = 1'b1;
    #1;
    check("t4_pred_old", pred_taken_f, 1'b0);
    check("t4_mis", mispredict, 1'b0);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    check("t4_pred_new", pred_taken_f, 1'b1);

    // Not-taken training walks 0x3000 down 11 -> 10 -> 01
    @(negedge clk);
    pc_f = 32'h3000; pc_d = 32'h3000; cmp_op = CMP_BNE; pred_taken_d = 1'b0; res_valid = 1'b1;
    #1;
    check("t4_dec_pre", pred_taken_f, 1'b1);
    @(negedge clk); #1;
    check("t4_dec_1", pred_taken_f, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    check("t4_dec_2", pred_taken_f, 1'b0);
    check("t4_branch_cnt", branch_cnt, 32'd6);
    check("t4_miss_cnt", miss_cnt, 32'd3);

    // Flush with a colliding training request; busy lasts exactly 64 cycles
    @(negedge clk);
    pc_f = 32'h3008; pc_d = 32'h3008; cmp_op = CMP_BEQ; pred_taken_d = 1'b0;
    res_valid = 1'b1; flush_req = 1'b1;
    #1;
    check("t5_busy_pre", busy, 1'b0);
    check("t5_pred_pre", pred_taken_f, 1'b1);
    @(negedge clk);
    flush_req = 1'b0;
    cycles = 0; bad_pred = 0;
    while (busy === 1'b1 && cycles < 200) begin
      if (pred_taken_f !== 1'b0) bad_pred++;
      if (cycles == 2) check("t5_mis_busy", mispredict, 1'b1);
      if (cycles == 5) flush_req = 1'b1;
      if (cycles == 6) flush_req = 1'b0;
      cycles++;
      @(negedge clk);
    end
    res_valid = 1'b0; flush_req = 1'b0;
    check("t5_busy_cycles", 32'(cycles), 32'd64);
    check("t5_pred_busy_nonzero", 32'(bad_pred), 32'd0);
    check("t5_branch_cnt", branch_cnt, 32'd6);
    check("t5_miss_cnt", miss_cnt, 32'd3);
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      pc_f = 32'h3000 + 32'(i * 4);
      #1;
      if (pred_taken_f !== 1'b0) ones++;
    end
    check("t5_all_entries_msb", 32'(ones), 32'd0);
    @(negedge clk);
    pc_d = 32'h3008; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0; pc_f = 32'h3008;
    #1;
    check("t5_init_is_wnt", pred_taken_f, 1'b1);
    check("t5_branch_cnt_after", branch_cnt, 32'd7);
    check("t5_miss_cnt_after", miss_cnt, 32'd4);

    // Reset in the middle of a flush
    @(negedge clk);
    pc_d = 32'hA0; res_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res_valid = 1'b0; pc_f = 32'hA0;
    #1;
    check("t6_pred_trained", pred_taken_f, 1'b1);
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("t6_busy_mid", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_busy_reset", busy, 1'b0);
    check("t6_pred_reset", pred_taken_f, 1'b0);
    check("t6_branch_cnt_reset", branch_cnt, 32'd0);
    check("t6_miss_cnt_reset", miss_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Narrow statistics saturate at all-ones
    cmp_op = CMP_BEQ; gpr_rs = 32'd5; gpr_rt = 32'd5; pred_taken_d = 1'b0; pc_d = 32'h0;
    res_valid2 = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    check("t6_miss_cnt4_14", 32'(miss_cnt2), 32'hE);
    check("t6_branch_cnt4_14", 32'(branch_cnt2), 32'hE);
    repeat (6) @(negedge clk);
    res_valid2 = 1'b0;
    #1;
    check("t6_miss_cnt4_sat", 32'(miss_cnt2), 32'hF);
    check("t6_branch_cnt4_sat", 32'(branch_cnt2), 32'hF);
    check("t6_dut_idle_stats", branch_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
